// File: rtl/i2c_cmd_sequencer_pkg.sv
// ============================================================================
// Module   : i2c_seq_pkg
// Purpose  : Shared types and field layout for the I2C command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_seq_pkg;

    // Command entry layout: {op, addr[6:0], data[7:0]}
    localparam int CMD_W        = 16;
    localparam int CMD_DATA_LSB = 0;
    localparam int CMD_DATA_W   = 8;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_ADDR_W   = 7;
    localparam int CMD_OP_BIT   = 15;

    // Response record: {data[7:0], err, tries[1:0]}
    localparam int RSP_W        = 11;

    // Cycles allowed for the master to raise busy after a launch
    localparam int BUSY_WAIT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4,
        ST_GAP       = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic [1:0] tries;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_sequencer_if.sv
// ============================================================================
// Module   : i2c_cmd_sequencer_if
// Purpose  : Host command/response and I2C master request/status bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_op;
    logic [7:0] cmd_data;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [1:0] rsp_tries;

    logic       m_newd;
    logic [7:0] m_din;
    logic [6:0] m_waddr;
    logic       m_op;
    logic       m_done;
    logic       m_ack_err;
    logic       m_busy;
    logic [7:0] m_dout;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_addr, cmd_op, cmd_data, rsp_ready,
        input  m_done, m_ack_err, m_busy, m_dout,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tries,
        output m_newd, m_din, m_waddr, m_op
    );

    // Host and byte-master side
    modport master (
        output cmd_valid, cmd_addr, cmd_op, cmd_data, rsp_ready,
        output m_done, m_ack_err, m_busy, m_dout,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tries,
        input  m_newd, m_din, m_waddr, m_op
    );

endinterface

`default_nettype wire

// File: rtl/i2c_cmd_sequencer_fifo.sv
// ============================================================================
// Module   : i2c_cmd_fifo
// Purpose  : Synchronous command FIFO with full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (count_q == CW'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_rdata   = mem_q[rd_ptr_q];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(w_do_push);
        rd_ptr_d = rd_ptr_q + AW'(w_do_pop);
        count_d  = count_q + CW'(w_do_push) - CW'(w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
// ============================================================================
// Module   : i2c_cmd_sequencer
// Purpose  : Queues host I2C byte commands, launches them on the byte master
//            with retry, idle gap and watchdog, and returns one response each.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RETRIES = 2,
    parameter int GAP     = 40,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               rst,
    i2c_cmd_sequencer_if.slave bus
);

    localparam int GAP_CW = $clog2(GAP + 1);
    localparam int WD_RAW = $clog2(TIMEOUT + 1);
    localparam int WD_CW  = (WD_RAW > 3) ? WD_RAW : 3;

    seq_state_e        state_q,   state_d;
    logic [1:0]        tries_q,   tries_d;
    logic              retry_q,   retry_d;
    logic              err_q,     err_d;
    logic [7:0]        rdata_q,   rdata_d;
    logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [WD_CW-1:0]  wd_cnt_q,  wd_cnt_d;
    logic              m_newd_q,  m_newd_d;
    logic [7:0]        m_din_q,   m_din_d;
    logic [6:0]        m_waddr_q, m_waddr_d;
    logic              m_op_q,    m_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_t              rsp_q,     rsp_d;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CMD_W-1:0]  w_head;
    logic [CMD_W-1:0]  w_cmd;

    assign w_cmd  = {bus.cmd_op, bus.cmd_addr, bus.cmd_data};
    assign w_push = bus.cmd_valid && !w_full;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        retry_d     = retry_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        gap_cnt_d   = '0;
        wd_cnt_d    = '0;
        m_din_d     = m_din_q;
        m_waddr_d   = m_waddr_q;
        m_op_d      = m_op_q;
        // Request strobe trails the LAUNCH state by one register stage
        m_newd_d    = (state_q == ST_LAUNCH);
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
        w_pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    state_d   = ST_LAUNCH;
                    m_din_d   = w_head[CMD_DATA_LSB +: CMD_DATA_W];
                    m_waddr_d = w_head[CMD_ADDR_LSB +: CMD_ADDR_W];
                    m_op_d    = w_head[CMD_OP_BIT];
                    err_d     = 1'b0;
                    rdata_d   = 8'h00;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.m_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (wd_cnt_q == WD_CW'(BUSY_WAIT - 1)) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                // ack_err is only valid in the m_done cycle
                if (bus.m_done) begin
                    rdata_d = m_op_q ? bus.m_dout : 8'h00;
                    if (!bus.m_ack_err) begin
                        state_d = ST_RESP;
                        err_d   = 1'b0;
                    end else if (tries_q < 2'(RETRIES)) begin
                        tries_d = tries_q + 2'd1;
                        retry_d = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end
                end else if (wd_cnt_q == WD_CW'(TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_CW'(1);
                end
            end
            ST_RESP: begin
                if (!rsp_valid_q || bus.rsp_ready) begin
                    rsp_d.data  = rdata_q;
                    rsp_d.err   = err_q;
                    rsp_d.tries = tries_q;
                    rsp_valid_d = 1'b1;
                    w_pop       = 1'b1;
                    tries_d     = 2'd0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_CW'(GAP - 1)) begin
                    state_d = retry_q ? ST_LAUNCH : ST_IDLE;
                    retry_d = 1'b0;
                    rdata_d = 8'h00;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tries_q     <= 2'd0;
            retry_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            gap_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            m_newd_q    <= 1'b0;
            m_din_q     <= 8'h00;
            m_waddr_q   <= 7'h00;
            m_op_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            gap_cnt_q   <= gap_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            m_newd_q    <= m_newd_d;
            m_din_q     <= m_din_d;
            m_waddr_q   <= m_waddr_d;
            m_op_q      <= m_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_q.data;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.rsp_tries = rsp_q.tries;
    assign bus.m_newd    = m_newd_q;
    assign bus.m_din     = m_din_q;
    assign bus.m_waddr   = m_waddr_q;
    assign bus.m_op      = m_op_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
// ============================================================================
// Module   : tb_i2c_cmd_sequencer
// Purpose  : Directed self-checking bench with a simple I2C byte-master model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cmd_sequencer;

    localparam int C_DEPTH   = 4;
    localparam int C_RETRIES = 2;
    localparam int C_GAP     = 8;
    localparam int C_TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst;

    i2c_cmd_sequencer_if bus ();

    i2c_cmd_sequencer #(
        .DEPTH   (C_DEPTH),
        .RETRIES (C_RETRIES),
        .GAP     (C_GAP),
        .TIMEOUT (C_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor state
    int          cyc       = 0;
    int          newd_cnt  = 0;
    int          last_done = -1000;
    int          last_newd = 0;
    int          rsp_cyc   = 0;
    int          newd_long = 0;
    logic        newd_prev = 1'b0;
    int          newd_gap_q[$];
    logic [10:0] rsp_q[$];

    // Master model state
    logic hang = 1'b0;
    logic hung;
    int   mcnt;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            newd_prev = 1'b0;
        end else begin
            if (bus.m_done) last_done = cyc;
            if (bus.m_newd) begin
                newd_cnt++;
                last_newd = cyc;
                newd_gap_q.push_back(cyc - last_done);
                if (newd_prev) newd_long++;
            end
            newd_prev = bus.m_newd;
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_q.push_back({bus.rsp_data, bus.rsp_err, bus.rsp_tries});
                rsp_cyc = cyc;
            end
        end
    end

    // Byte master: busy for a few cycles, then one-cycle done; 0x22 NACKs,
    // reads return {0,addr}^0x54, writes leave junk on m_dout.
    always @(posedge clk) begin
        if (rst) begin
            bus.m_busy    <= 1'b0;
            bus.m_done    <= 1'b0;
            bus.m_ack_err <= 1'b0;
            bus.m_dout    <= 8'h00;
            mcnt          <= 0;
            hung          <= 1'b0;
        end else begin
            bus.m_done    <= 1'b0;
            bus.m_ack_err <= 1'b0;
            if (hung) begin
                if (!hang) begin
                    hung       <= 1'b0;
                    bus.m_busy <= 1'b0;
                end
            end else if (bus.m_busy) begin
                if (mcnt == 5) begin
                    bus.m_busy    <= 1'b0;
                    bus.m_done    <= 1'b1;
                    bus.m_ack_err <= (bus.m_waddr == 7'h22);
                    bus.m_dout    <= bus.m_op ? ({1'b0, bus.m_waddr} ^ 8'h54) : 8'hEE;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end else if (bus.m_newd) begin
                bus.m_busy <= 1'b1;
                mcnt       <= 0;
                hung       <= hang;
            end
        end
    end

    task automatic push(input logic op, input logic [6:0] addr, input logic [7:0] data,
                        output bit ok);
        int t;
        t = 0;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = bus.cmd_ready;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int limit, output bit ok);
        int t;
        t = 0;
        while (rsp_q.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        ok = (rsp_q.size() >= n);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = 7'h00;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_tries} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_rsp: got %h want 000",
                     {bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_tries});
        end
        vectors++;
        if ({bus.m_newd, bus.m_op, bus.m_waddr, bus.m_din} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_m_fields: got %h want 0",
                     {bus.m_newd, bus.m_op, bus.m_waddr, bus.m_din});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        bit          ok;
        int          n0;
        logic [3:0]  pat;
        logic [15:0] fields;
        logic [10:0] r;
        n0 = newd_cnt;
        push(1'b0, 7'h50, 8'hA5, ok);
        pat[3] = bus.m_newd;
        @(negedge clk);
        pat[2] = bus.m_newd;
        @(negedge clk);
        pat[1] = bus.m_newd;
        fields = {bus.m_op, bus.m_waddr, bus.m_din};
        @(negedge clk);
        pat[0] = bus.m_newd;
        vectors++;
        if (pat !== 4'b0010) begin
            miscompares++;
            $display("FAIL write_newd_timing: got %b want 0010", pat);
        end
        vectors++;
        if (fields !== {1'b0, 7'h50, 8'hA5}) begin
            miscompares++;
            $display("FAIL write_m_fields: got %h want %h", fields, {1'b0, 7'h50, 8'hA5});
        end
        wait_rsp(1, 500, ok);
        r = ok ? rsp_q.pop_front() : 11'h7FF;
        vectors++;
        if (r !== {8'h00, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL write_rsp: got %h want %h", r, {8'h00, 1'b0, 2'd0});
        end
        vectors++;
        if (newd_cnt - n0 !== 1 || newd_long !== 0) begin
            miscompares++;
            $display("FAIL write_newd_count: got %0d (long %0d) want 1 (long 0)",
                     newd_cnt - n0, newd_long);
        end
        repeat (C_GAP + 5) @(negedge clk);
    endtask

    task automatic test_read();
        bit          ok;
        logic [10:0] r;
        push(1'b1, 7'h68, 8'h00, ok);
        wait_rsp(1, 500, ok);
        r = ok ? rsp_q.pop_front() : 11'h7FF;
        vectors++;
        if (r !== {8'h3C, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL read_rsp: got %h want %h", r, {8'h3C, 1'b0, 2'd0});
        end
        vectors++;
        if ({bus.m_op, bus.m_waddr} !== {1'b1, 7'h68}) begin
            miscompares++;
            $display("FAIL read_m_fields: got %h want %h", {bus.m_op, bus.m_waddr}, {1'b1, 7'h68});
        end
        repeat (C_GAP + 5) @(negedge clk);
    endtask

    task automatic test_retry();
        bit          ok;
        int          n0;
        logic [10:0] r;
        n0 = newd_cnt;
        newd_gap_q.delete();
        push(1'b0, 7'h22, 8'h5A, ok);
        wait_rsp(1, 1000, ok);
        r = ok ? rsp_q.pop_front() : 11'h7FF;
        vectors++;
        if (r !== {8'h00, 1'b1, 2'd2}) begin
            miscompares++;
            $display("FAIL retry_rsp: got %h want %h", r, {8'h00, 1'b1, 2'd2});
        end
        vectors++;
        if (newd_cnt - n0 !== 3 || newd_gap_q.size() != 3) begin
            miscompares++;
            $display("FAIL retry_launches: got %0d want 3", newd_cnt - n0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (newd_gap_q[i] !== C_GAP + 2) begin
                    miscompares++;
                    $display("FAIL retry_spacing%0d: got %0d want %0d", i, newd_gap_q[i], C_GAP + 2);
                end
            end
        end
        repeat (C_GAP + 5) @(negedge clk);
    endtask

    task automatic test_full_stall();
        bit          ok;
        bit          all_ok;
        int          n0;
        logic [10:0] r;
        logic [7:0]  exp_d [5];
        exp_d = '{8'h44, 8'h45, 8'h46, 8'h47, 8'h40};
        n0 = newd_cnt;
        bus.rsp_ready = 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 7'h10 + 7'(i), 8'h00, ok);
            all_ok &= ok;
        end
        vectors++;
        if (!all_ok || bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_after_4: got accepted=%b cmd_ready=%b want 1 0", all_ok, bus.cmd_ready);
        end
        push(1'b1, 7'h14, 8'h00, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL full_push5: got not accepted want accepted");
        end
        repeat (120) @(negedge clk);
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data} !== {1'b0, 1'b1, 8'h44}) begin
            miscompares++;
            $display("FAIL full_stall_state: got %h want %h",
                     {bus.cmd_ready, bus.rsp_valid, bus.rsp_data}, {1'b0, 1'b1, 8'h44});
        end
        vectors++;
        if (newd_cnt - n0 !== 2 || rsp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_stall_launches: got %0d launches %0d rsps want 2 0",
                     newd_cnt - n0, rsp_q.size());
        end
        bus.rsp_ready = 1'b1;
        wait_rsp(5, 2000, ok);
        for (int i = 0; i < 5; i++) begin
            r = (rsp_q.size() > 0) ? rsp_q.pop_front() : 11'h7FF;
            vectors++;
            if (r !== {exp_d[i], 1'b0, 2'd0}) begin
                miscompares++;
                $display("FAIL full_drain%0d: got %h want %h", i, r, {exp_d[i], 1'b0, 2'd0});
            end
        end
        repeat (C_GAP + 5) @(negedge clk);
    endtask

    task automatic test_watchdog();
        bit          ok;
        int          n0;
        int          elapsed;
        logic [10:0] r;
        n0 = newd_cnt;
        hang = 1'b1;
        push(1'b0, 7'h40, 8'h11, ok);
        wait_rsp(1, C_TIMEOUT + 200, ok);
        elapsed = rsp_cyc - last_newd;
        r = ok ? rsp_q.pop_front() : 11'h7FF;
        vectors++;
        if (r !== {8'h00, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL wdog_rsp: got %h want %h", r, {8'h00, 1'b1, 2'd0});
        end
        vectors++;
        if (!ok || elapsed < C_TIMEOUT || elapsed > C_TIMEOUT + 10) begin
            miscompares++;
            $display("FAIL wdog_elapsed: got %0d want %0d..%0d", elapsed, C_TIMEOUT, C_TIMEOUT + 10);
        end
        hang = 1'b0;
        repeat (C_GAP + 5) @(negedge clk);
        push(1'b1, 7'h68, 8'h00, ok);
        wait_rsp(1, 500, ok);
        r = ok ? rsp_q.pop_front() : 11'h7FF;
        vectors++;
        if (r !== {8'h3C, 1'b0, 2'd0} || newd_cnt - n0 !== 2) begin
            miscompares++;
            $display("FAIL wdog_next_cmd: got %h launches %0d want %h launches 2",
                     r, newd_cnt - n0, {8'h3C, 1'b0, 2'd0});
        end
        repeat (C_GAP + 5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit          ok;
        int          n0;
        int          r0;
        int          t;
        logic [10:0] r;
        n0 = newd_cnt;
        r0 = rsp_q.size();
        push(1'b0, 7'h50, 8'h01, ok);
        push(1'b0, 7'h51, 8'h02, ok);
        t = 0;
        while (!bus.m_busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        vectors++;
        if (bus.m_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy: got %b want 1", bus.m_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_tries} !== {1'b1, 12'h000}) begin
            miscompares++;
            $display("FAIL rstmid_host_side: got %h want %h",
                     {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_tries},
                     {1'b1, 12'h000});
        end
        vectors++;
        if ({bus.m_newd, bus.m_op, bus.m_waddr, bus.m_din} !== 17'h0) begin
            miscompares++;
            $display("FAIL rstmid_m_fields: got %h want 0",
                     {bus.m_newd, bus.m_op, bus.m_waddr, bus.m_din});
        end
        rst = 1'b0;
        repeat (60) @(negedge clk);
        vectors++;
        if (newd_cnt - n0 !== 1 || rsp_q.size() != r0) begin
            miscompares++;
            $display("FAIL rstmid_flushed: got %0d launches %0d rsps want 1 %0d",
                     newd_cnt - n0, rsp_q.size(), r0);
        end
        push(1'b1, 7'h68, 8'h00, ok);
        wait_rsp(r0 + 1, 500, ok);
        r = ok ? rsp_q.pop_front() : 11'h7FF;
        vectors++;
        if (r !== {8'h3C, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL rstmid_after: got %h want %h", r, {8'h3C, 1'b0, 2'd0});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_retry();
        test_full_stall();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
